// File: rtl/vga_mmio_pkg.sv
// Shared screen-window memory map and DMA state encoding, used by the DMA master,
// the system bus mux and the bench monitor.
package vga_mmio_pkg;

  localparam logic [15:0] VRAM_BASE      = 16'h0200;
  localparam logic [15:0] VRAM_SIZE      = 16'h0400;
  localparam logic [15:0] COPY_REG_ADDR  = 16'h4015;
  localparam logic [15:0] FILL_REG_ADDR  = 16'h4016;

  typedef enum logic [2:0] {
    DMA_IDLE    = 3'd0,
    DMA_HALT    = 3'd1,
    DMA_READ    = 3'd2,
    DMA_CAPTURE = 3'd3,
    DMA_WRITE   = 3'd4,
    DMA_FILL    = 3'd5,
    DMA_DONE    = 3'd6
  } dma_state_t;

endpackage

// File: rtl/vga_dma_master.sv
// Bus initiator that halts the CPU and either copies a 1 KiB source range into the
// VGA screen window or fills the window with a constant byte.
module vga_dma_master
  import vga_mmio_pkg::*;
#(
  parameter logic [15:0] DST_BASE = VRAM_BASE,
  parameter int          LEN      = 1024,
  parameter logic [15:0] COPY_REG = COPY_REG_ADDR,
  parameter logic [15:0] FILL_REG = FILL_REG_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_rw,
  input  logic [7:0]  rd_data,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data,
  output logic        bus_rw,
  output logic        bus_own,
  output logic        cpu_halt,
  output logic        busy,
  output logic        done
);

  dma_state_t  r_state;
  dma_state_t  w_nextState;
  logic [10:0] r_idx;
  logic [10:0] w_nextIdx;
  logic [15:0] r_src;
  logic [15:0] r_lastAddr;
  logic [7:0]  r_fillVal;
  logic [7:0]  r_dataQ;
  logic [7:0]  r_lastData;
  logic        r_modeFill;
  logic        w_trigCopy;
  logic        w_trigFill;
  logic        w_lastIdx;

  assign w_trigCopy = !cpu_rw && (cpu_addr == COPY_REG);
  assign w_trigFill = !cpu_rw && (cpu_addr == FILL_REG);
  assign w_lastIdx  = (r_idx == 11'(LEN - 1));

  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    unique case (r_state)
      DMA_IDLE:    if (w_trigCopy || w_trigFill) w_nextState = DMA_HALT;
      DMA_HALT:    w_nextState = r_modeFill ? DMA_FILL : DMA_READ;
      DMA_READ:    w_nextState = DMA_CAPTURE;
      DMA_CAPTURE: w_nextState = DMA_WRITE;
      DMA_WRITE: begin
        w_nextIdx   = r_idx + 11'd1;
        w_nextState = w_lastIdx ? DMA_DONE : DMA_READ;
      end
      DMA_FILL: begin
        w_nextIdx   = r_idx + 11'd1;
        w_nextState = w_lastIdx ? DMA_DONE : DMA_FILL;
      end
      DMA_DONE: begin
        w_nextIdx   = '0;
        w_nextState = DMA_IDLE;
      end
      default:     w_nextState = DMA_IDLE;
    endcase
  end

  // Outside the bus-owning states the address/data lines keep their last driven value.
  always_comb begin
    bus_addr = r_lastAddr;
    bus_data = r_lastData;
    bus_rw   = 1'b1;
    bus_own  = 1'b0;
    cpu_halt = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      DMA_HALT: begin
        cpu_halt = 1'b1;
        busy     = 1'b1;
      end
      DMA_READ, DMA_CAPTURE: begin
        bus_own  = 1'b1;
        cpu_halt = 1'b1;
        busy     = 1'b1;
        bus_addr = r_src + {5'd0, r_idx};
      end
      DMA_WRITE, DMA_FILL: begin
        bus_own  = 1'b1;
        bus_rw   = 1'b0;
        cpu_halt = 1'b1;
        busy     = 1'b1;
        bus_addr = DST_BASE + {5'd0, r_idx};
        bus_data = (r_state == DMA_FILL) ? r_fillVal : r_dataQ;
      end
      DMA_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        bus_own = 1'b0;
      end
    endcase
  end

  // Triggers are only accepted while idle; anything arriving mid-transfer is dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= DMA_IDLE;
      r_idx      <= '0;
      r_src      <= '0;
      r_fillVal  <= '0;
      r_dataQ    <= '0;
      r_modeFill <= 1'b0;
      r_lastAddr <= '0;
      r_lastData <= '0;
    end else begin
      r_state    <= w_nextState;
      r_idx      <= w_nextIdx;
      r_lastAddr <= bus_addr;
      r_lastData <= bus_data;
      if (r_state == DMA_IDLE && (w_trigCopy || w_trigFill)) begin
        r_modeFill <= w_trigFill;
        if (w_trigFill) r_fillVal <= cpu_data;
        else            r_src     <= {cpu_data, 8'h00};
      end
      if (r_state == DMA_CAPTURE) r_dataQ <= rd_data;
    end
  end

endmodule

// File: tb/tb_vga_dma_master.sv
// Self-checking bench: a byte-array bus responder plus a reference model that replays
// each transfer as a plain indexed copy/fill over a 64 KiB array.
module tb_vga_dma_master;
  import vga_mmio_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data = 8'h00;
  logic        cpu_rw = 1'b1;
  logic [7:0]  rd_data;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data;
  logic        bus_rw, bus_own, cpu_halt, busy, done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem   [65536];
  logic [7:0]  stage [65536];
  logic [7:0]  model [65536];
  logic        loadReq = 1'b0;

  logic [15:0] wrAddrQ[$];
  logic [7:0]  wrDataQ[$];
  logic [15:0] rdAddrQ[$];
  logic [15:0] expWrAddr[$];
  logic [7:0]  expWrData[$];
  logic [15:0] expRdAddr[$];

  int doneCount = 0, conflictCount = 0, rwLowCount = 0;
  int cyc = 0, trigCyc = 0;
  int wrBase = 0, rdBase = 0, doneBase = 0, rwBase = 0;
  logic prevRd = 1'b0;

  vga_dma_master dut (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_rw(cpu_rw),
    .rd_data(rd_data),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_rw(bus_rw),
    .bus_own(bus_own), .cpu_halt(cpu_halt), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Screen/system memory responder: read data appears the cycle after the address.
  always @(posedge clock) begin
    if (loadReq) begin
      for (int k = 0; k < 65536; k++) mem[k] <= stage[k];
    end else if (bus_own) begin
      rd_data <= mem[bus_addr];
      if (!bus_rw) mem[bus_addr] <= bus_data;
    end
  end

  always @(negedge clock) begin
    if (bus_own && !bus_rw) begin
      wrAddrQ.push_back(bus_addr);
      wrDataQ.push_back(bus_data);
    end
    if (bus_own && bus_rw && !prevRd) rdAddrQ.push_back(bus_addr);
    prevRd = bus_own && bus_rw;
    if (done) doneCount++;
    if (bus_own && !cpu_halt) conflictCount++;
    if (!bus_rw) rwLowCount++;
  end

  task automatic syncStage();
    for (int k = 0; k < 65536; k++) stage[k] = mem[k];
  endtask

  task automatic loadMem();
    @(negedge clock);
    loadReq = 1'b1;
    @(posedge clock);
    #1;
    loadReq = 1'b0;
  endtask

  // Reference behaviour: byte k of the window takes src[k] (read after all earlier writes) or the fill value.
  task automatic buildExpected(input bit isFill, input logic [7:0] val);
    expWrAddr.delete();
    expWrData.delete();
    expRdAddr.delete();
    for (int k = 0; k < 1024; k++) begin
      logic [15:0] dst, src;
      logic [7:0]  d;
      dst = 16'(32'h0200 + k);
      if (isFill) d = val;
      else begin
        src = 16'({val, 8'h00} + k);
        expRdAddr.push_back(src);
        d = model[src];
      end
      model[dst] = d;
      expWrAddr.push_back(dst);
      expWrData.push_back(d);
    end
  endtask

  task automatic cpuWrite(input logic [15:0] addr, input logic [7:0] data, input bit record);
    @(negedge clock);
    cpu_addr = addr;
    cpu_data = data;
    cpu_rw   = 1'b0;
    @(posedge clock);
    #1;
    cpu_rw   = 1'b1;
    cpu_addr = 16'h0000;
    if (record) trigCyc = cyc;
  endtask

  task automatic startTransfer(input bit isFill, input logic [7:0] val);
    loadMem();
    model = stage;
    buildExpected(isFill, val);
    wrBase   = wrAddrQ.size();
    rdBase   = rdAddrQ.size();
    doneBase = doneCount;
    rwBase   = rwLowCount;
    cpuWrite(isFill ? FILL_REG_ADDR : COPY_REG_ADDR, val, 1'b1);
  endtask

  task automatic waitDone(input int budget, output int n);
    n = cyc - trigCyc + 1;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clock);
      #1;
      n = cyc - trigCyc + 1;
    end
  endtask

  function automatic int writeDiff();
    if (wrAddrQ.size() - wrBase != expWrAddr.size()) return -2;
    foreach (expWrAddr[k])
      if (wrAddrQ[wrBase + k] !== expWrAddr[k] || wrDataQ[wrBase + k] !== expWrData[k]) return k;
    return -1;
  endfunction

  function automatic int readDiff();
    if (rdAddrQ.size() - rdBase != expRdAddr.size()) return -2;
    foreach (expRdAddr[k])
      if (rdAddrQ[rdBase + k] !== expRdAddr[k]) return k;
    return -1;
  endfunction

  function automatic int memDiff();
    for (int k = 0; k < 65536; k++)
      if (mem[k] !== model[k]) return k;
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({bus_addr, bus_data, bus_rw, bus_own, cpu_halt, busy, done} !== {16'h0000, 8'h00, 5'b10000}) begin
      errors++;
      $display("[TB] FAIL reset_outputs got addr=%h data=%h rw=%b own=%b halt=%b busy=%b done=%b want 0000/00/1/0/0/0/0",
               bus_addr, bus_data, bus_rw, bus_own, cpu_halt, busy, done);
    end
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || bus_own !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got busy=%b own=%b want 0/0", busy, bus_own);
    end
  endtask

  task automatic test_fill();
    logic [7:0] v;
    int n, d;
    v = 8'h5A;
    syncStage();
    startTransfer(1'b1, v);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fill_busy_next_cycle got %b want 1", busy);
    end
    waitDone(4000, n);
    checks++;
    if (n != 1026 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fill_latency got %0d (done=%b) want 1026", n, done);
    end
    @(posedge clock);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || doneCount - doneBase != 1) begin
      errors++;
      $display("[TB] FAIL fill_done_pulse got done=%b busy=%b pulses=%0d want 0/0/1", done, busy, doneCount - doneBase);
    end
    d = writeDiff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("[TB] FAIL fill_writes got first bad index %0d (count %0d) want none", d, wrAddrQ.size() - wrBase);
    end
    d = 0;
    for (int k = 0; k < 1024; k++) if (mem[16'h0200 + k] !== v) d++;
    checks++;
    if (d != 0 || rdAddrQ.size() != rdBase) begin
      errors++;
      $display("[TB] FAIL fill_window got %0d bad bytes, %0d reads want 0/0", d, rdAddrQ.size() - rdBase);
    end
  endtask

  task automatic test_copy();
    int n, d;
    syncStage();
    for (int k = 0; k < 1024; k++) stage[16'h3000 + k] = 8'(k) ^ 8'hA5;
    startTransfer(1'b0, 8'h30);
    waitDone(4000, n);
    checks++;
    if (n != 3074 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL copy_latency got %0d (done=%b) want 3074", n, done);
    end
    @(posedge clock);
    #1;
    checks++;
    if (rwLowCount - rwBase != 1024) begin
      errors++;
      $display("[TB] FAIL copy_rw_low_cycles got %0d want 1024", rwLowCount - rwBase);
    end
    d = 0;
    for (int k = 0; k < 1024; k++) if (mem[16'h0200 + k] !== (8'(k) ^ 8'hA5)) d++;
    checks++;
    if (d != 0) begin
      errors++;
      $display("[TB] FAIL copy_window got %0d bad bytes want 0", d);
    end
    d = readDiff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("[TB] FAIL copy_reads got first bad index %0d want none", d);
    end
  endtask

  task automatic test_source_wrap();
    int n, d;
    syncStage();
    for (int k = 0; k < 512; k++) begin
      stage[16'hFE00 + k] = 8'($urandom);
      stage[k]            = 8'($urandom);
    end
    startTransfer(1'b0, 8'hFE);
    waitDone(4000, n);
    checks++;
    if (n != 3074) begin
      errors++;
      $display("[TB] FAIL wrap_latency got %0d want 3074", n);
    end
    @(posedge clock);
    #1;
    d = readDiff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("[TB] FAIL wrap_reads got first bad index %0d want none", d);
    end
    d = writeDiff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("[TB] FAIL wrap_writes got first bad index %0d want none", d);
    end
    d = memDiff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("[TB] FAIL wrap_memory got first bad addr %0d want none", d);
    end
  endtask

  task automatic test_overlap();
    int n, d;
    logic [7:0] p;
    p = 8'($urandom_range(2, 5));
    syncStage();
    for (int k = 16'h0200; k < 16'h0A00; k++) stage[k] = 8'($urandom);
    startTransfer(1'b0, p);
    waitDone(4000, n);
    @(posedge clock);
    #1;
    d = memDiff();
    checks++;
    if (d != -1 || n != 3074) begin
      errors++;
      $display("[TB] FAIL overlap_page_%0h got bad addr %0d latency %0d want none/3074", p, d, n);
    end
  endtask

  task automatic test_trigger_while_busy();
    logic [7:0] v;
    int n, d;
    v = 8'($urandom);
    syncStage();
    startTransfer(1'b1, v);
    repeat (200) @(posedge clock);
    cpuWrite(COPY_REG_ADDR, 8'h40, 1'b0);
    waitDone(4000, n);
    checks++;
    if (n != 1026) begin
      errors++;
      $display("[TB] FAIL busy_trigger_latency got %0d want 1026", n);
    end
    d = writeDiff();
    checks++;
    if (d != -1 || rdAddrQ.size() != rdBase) begin
      errors++;
      $display("[TB] FAIL busy_trigger_writes got bad index %0d reads %0d want none/0", d, rdAddrQ.size() - rdBase);
    end
    repeat (20) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || doneCount - doneBase != 1) begin
      errors++;
      $display("[TB] FAIL busy_trigger_not_queued got busy=%b pulses=%0d want 0/1", busy, doneCount - doneBase);
    end
  endtask

  task automatic test_halt_handshake();
    int n, c0;
    c0 = conflictCount;
    checks++;
    if (cpu_halt !== 1'b0 || bus_own !== 1'b0) begin
      errors++;
      $display("[TB] FAIL handshake_idle got halt=%b own=%b want 0/0", cpu_halt, bus_own);
    end
    syncStage();
    startTransfer(1'b0, 8'($urandom_range(8'h10, 8'h1F)));
    checks++;
    if (cpu_halt !== 1'b1 || bus_own !== 1'b0) begin
      errors++;
      $display("[TB] FAIL handshake_halt_cycle got halt=%b own=%b want 1/0", cpu_halt, bus_own);
    end
    @(posedge clock);
    #1;
    checks++;
    if (cpu_halt !== 1'b1 || bus_own !== 1'b1) begin
      errors++;
      $display("[TB] FAIL handshake_own_cycle got halt=%b own=%b want 1/1", cpu_halt, bus_own);
    end
    waitDone(4000, n);
    checks++;
    if (cpu_halt !== 1'b0 || bus_own !== 1'b0 || n != 3074) begin
      errors++;
      $display("[TB] FAIL handshake_release got halt=%b own=%b latency=%0d want 0/0/3074", cpu_halt, bus_own, n);
    end
    @(posedge clock);
    #1;
    checks++;
    if (conflictCount != c0 || memDiff() != -1) begin
      errors++;
      $display("[TB] FAIL handshake_no_conflict got %0d shared cycles, mem diff %0d want 0/-1", conflictCount - c0, memDiff());
    end
  endtask

  task automatic test_reset_mid_copy();
    int w0, t;
    syncStage();
    startTransfer(1'b0, 8'($urandom_range(8'h60, 8'h7F)));
    t = 0;
    while (wrAddrQ.size() - wrBase < 100 && t < 2000) begin
      @(posedge clock);
      #1;
      t++;
    end
    checks++;
    if (wrAddrQ.size() - wrBase != 100) begin
      errors++;
      $display("[TB] FAIL midreset_reach_idx got %0d writes want 100", wrAddrQ.size() - wrBase);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    checks++;
    if (bus_own !== 1'b0 || cpu_halt !== 1'b0 || bus_rw !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs got own=%b halt=%b rw=%b busy=%b want 0/0/1/0", bus_own, cpu_halt, bus_rw, busy);
    end
    w0 = wrAddrQ.size();
    repeat (50) @(posedge clock);
    #1;
    checks++;
    if (wrAddrQ.size() != w0 || busy !== 1'b0 || doneCount != doneBase) begin
      errors++;
      $display("[TB] FAIL midreset_quiet got %0d extra writes busy=%b pulses=%0d want 0/0/0",
               wrAddrQ.size() - w0, busy, doneCount - doneBase);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_source_wrap();
    test_overlap();
    test_trigger_while_busy();
    test_halt_handshake();
    test_reset_mid_copy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
